// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder (one full adder, one carry flop); ports clk/rst/start, A/B/Carry_in in, busy/done/SUM/Carry_out out, Overflow when SERIAL_ADDER_OVF_EN is defined
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             Carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Overflow
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] cnt;
  logic c, s, co, last;
  assign s = a_sr[0] ^ b_sr[0] ^ c;
  assign co = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == S_SHIFT;
  assign done = state == S_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_sr <= '0;
      b_sr <= '0;
      c <= 1'b0;
      cnt <= '0;
      SUM <= '0;
      Carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      Overflow <= 1'b0;
`endif
    end else if (state != S_SHIFT) begin
      state <= start ? S_SHIFT : S_IDLE;
      if (start) begin
        a_sr <= A;
        b_sr <= B;
        c <= Carry_in;
        cnt <= '0;
      end
    end else begin
      SUM <= {s, SUM[WIDTH-1:1]};
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      c <= co;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= S_DONE;
        Carry_out <= co;
`ifdef SERIAL_ADDER_OVF_EN
        Overflow <= c ^ co;
`endif
      end
    end
  end
endmodule
